// File: rtl/fb_port_arbiter.sv
// Frame-buffer RAM port arbiter: VGA scan-out reads take priority over byte-lane RMW write-back.
// Optional statistics counters (miss_count, wr_count) are enabled with `define FB_ARB_STATS_EN.
module fb_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int RAM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [31:0]       vga_rdata,
    output logic              vga_valid,
    output logic              vga_miss,
    input  logic              wr_req,
    input  logic [ADDR_W+1:0] wr_addr,
    input  logic [7:0]        wr_byte,
    output logic              wr_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    output logic              busy
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]       miss_count,
    output logic [15:0]       wr_count
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        VGA_RD  = 3'd1,
        RMW_RD  = 3'd2,
        RMW_MRG = 3'd3,
        RMW_WR  = 3'd4,
        WR_HOLD = 3'd5
    } state_t;

    localparam logic [2:0] LAT_C  = 3'(RAM_LAT);
    localparam logic [2:0] LAT_M1 = 3'(RAM_LAT - 1);

    state_t              state_q;
    logic [2:0]          cnt_q;
    logic                pend_q;
    logic [ADDR_W-1:0]   pend_addr_q;
    logic [1:0]          lane_q;
    logic [7:0]          byte_q;
    logic [31:0]         vga_rdata_q;
    logic                vga_valid_q;
    logic                vga_miss_q;
    logic                wr_done_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [31:0]         ram_wdata_q;
    logic                ram_we_q;
    logic                busy_q;
    logic [31:0]         merged_d;
    logic                miss_evt;

    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  pix);
        logic [31:0] res;
        res = word;
        case (lane)
            2'd0:    res[7:0]   = pix;
            2'd1:    res[15:8]  = pix;
            2'd2:    res[23:16] = pix;
            2'd3:    res[31:24] = pix;
            default: res        = word;
        endcase
        return res;
    endfunction

    // Merged write word and pending-slot overflow detection.
    always_comb begin
        merged_d = merge_lane(ram_rdata, lane_q, byte_q);
        miss_evt = vga_req && pend_q && (state_q != IDLE);
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            lane_q      <= 2'd0;
            byte_q      <= 8'd0;
            vga_rdata_q <= 32'd0;
            vga_valid_q <= 1'b0;
            vga_miss_q  <= 1'b0;
            wr_done_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'd0;
            ram_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            vga_valid_q <= 1'b0;
            ram_we_q    <= 1'b0;
            if (wr_done_q && !wr_req) begin
                wr_done_q <= 1'b0;
            end
            // VGA requests that find the port occupied go to the one-deep pending slot.
            if ((state_q != IDLE) && vga_req) begin
                pend_q      <= 1'b1;
                pend_addr_q <= vga_addr;
            end
            if (miss_evt) begin
                vga_miss_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        ram_addr_q <= pend_addr_q;
                        cnt_q      <= 3'd0;
                        state_q    <= VGA_RD;
                        busy_q     <= 1'b1;
                        if (vga_req) begin
                            pend_addr_q <= vga_addr;
                        end else begin
                            pend_q <= 1'b0;
                        end
                    end else if (vga_req) begin
                        ram_addr_q <= vga_addr;
                        cnt_q      <= 3'd0;
                        state_q    <= VGA_RD;
                        busy_q     <= 1'b1;
                    end else if (wr_req && !wr_done_q) begin
                        ram_addr_q <= wr_addr[ADDR_W+1:2];
                        lane_q     <= wr_addr[1:0];
                        byte_q     <= wr_byte;
                        cnt_q      <= 3'd0;
                        state_q    <= RMW_RD;
                        busy_q     <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                VGA_RD: begin
                    if (cnt_q == LAT_C) begin
                        vga_rdata_q <= ram_rdata;
                        vga_valid_q <= 1'b1;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                RMW_RD: begin
                    if (cnt_q == LAT_M1) begin
                        state_q <= RMW_MRG;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                RMW_MRG: begin
                    ram_wdata_q <= merged_d;
                    ram_we_q    <= 1'b1;
                    state_q     <= RMW_WR;
                end
                RMW_WR: begin
                    state_q <= WR_HOLD;
                end
                WR_HOLD: begin
                    wr_done_q <= 1'b1;
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vga_rdata = vga_rdata_q;
    assign vga_valid = vga_valid_q;
    assign vga_miss  = vga_miss_q;
    assign wr_done   = wr_done_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign busy      = busy_q;

`ifdef FB_ARB_STATS_EN
    logic [15:0] miss_count_q;
    logic [15:0] wr_count_q;

    // Saturating miss counter and wrapping committed-write counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_count_q <= 16'd0;
            wr_count_q   <= 16'd0;
        end else begin
            if (miss_evt && (miss_count_q != 16'hFFFF)) begin
                miss_count_q <= miss_count_q + 16'd1;
            end
            if (ram_we_q) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    assign miss_count = miss_count_q;
    assign wr_count   = wr_count_q;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: behavioural RAM model plus read/write scoreboards.
module tb_fb_port_arbiter;
    localparam int ADDR_W = 16;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [31:0]       vga_rdata;
    logic              vga_valid;
    logic              vga_miss;
    logic              wr_req;
    logic [ADDR_W+1:0] wr_addr;
    logic [7:0]        wr_byte;
    logic              wr_done;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic [31:0]       ram_rdata;
    logic              busy;
`ifdef FB_ARB_STATS_EN
    logic [15:0]       miss_count;
    logic [15:0]       wr_count;
`endif

    int checks = 0;
    int passed = 0;
    int we_cnt = 0;

    logic [31:0] exp_vga_q[$];
    logic [31:0] obs_vga_q[$];
    logic [47:0] exp_wr_q[$];
    logic [47:0] obs_wr_q[$];

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [31:0]       pipe [0:LAT-1];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [31:0]       pl_data = 32'd0;

    always #10 clk = ~clk;

    fb_port_arbiter #(.ADDR_W(ADDR_W), .RAM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata),
        .vga_valid(vga_valid), .vga_miss(vga_miss),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_byte(wr_byte), .wr_done(wr_done),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .busy(busy)
`ifdef FB_ARB_STATS_EN
        , .miss_count(miss_count), .wr_count(wr_count)
`endif
    );

    // RAM model: registered address, LAT-stage read pipeline, write on ram_we.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        pipe[0] <= mem[ram_addr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata = pipe[LAT-1];

    // Observed-traffic monitor feeding the scoreboards.
    always @(posedge clk) begin
        if (vga_valid) obs_vga_q.push_back(vga_rdata);
        if (ram_we) begin
            we_cnt <= we_cnt + 1;
            obs_wr_q.push_back({ram_addr, ram_wdata});
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; vga_req = 1'b0; vga_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_byte = 8'd0;
        step(); step();
        checks++; if (vga_valid !== 1'b0) $display("FAIL reset_vga_valid: got %b want 0", vga_valid); else passed++;
        checks++; if (vga_rdata !== 32'd0) $display("FAIL reset_vga_rdata: got %h want 0", vga_rdata); else passed++;
        checks++; if (vga_miss !== 1'b0) $display("FAIL reset_vga_miss: got %b want 0", vga_miss); else passed++;
        checks++; if (wr_done !== 1'b0) $display("FAIL reset_wr_done: got %b want 0", wr_done); else passed++;
        checks++; if (ram_addr !== 16'd0) $display("FAIL reset_ram_addr: got %h want 0", ram_addr); else passed++;
        checks++; if (ram_wdata !== 32'd0) $display("FAIL reset_ram_wdata: got %h want 0", ram_wdata); else passed++;
        checks++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we: got %b want 0", ram_we); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_vga_read();
        int n;
        logic [31:0] got, exp;
        preload(16'd5, 32'h44332211);
        exp_vga_q.push_back(32'h44332211);
        vga_req = 1'b1; vga_addr = 16'd5;
        step();
        vga_req = 1'b0;
        n = 0;
        while (!vga_valid && n < 30) begin step(); n++; end
        checks++; if (n !== LAT + 1) $display("FAIL vga_latency: got %0d want %0d", n, LAT + 1); else passed++;
        step();
        checks++; if (vga_valid !== 1'b0) $display("FAIL vga_valid_one_cycle: got %b want 0", vga_valid); else passed++;
        checks++;
        if (obs_vga_q.size() == 0 || exp_vga_q.size() == 0) $display("FAIL vga_data: got %0d reads want 1", obs_vga_q.size());
        else begin
            got = obs_vga_q.pop_front(); exp = exp_vga_q.pop_front();
            if (got !== exp) $display("FAIL vga_data: got %h want %h", got, exp); else passed++;
        end
        checks++; if (we_cnt !== 0) $display("FAIL vga_no_write: got %0d writes want 0", we_cnt); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL vga_busy_after: got %b want 0", busy); else passed++;
    endtask

    task automatic test_rmw();
        int n, base;
        logic [47:0] got, exp;
        preload(16'h0010, 32'hAABBCCDD);
        base = we_cnt;
        exp_wr_q.push_back({16'h0010, 32'hAA5ACCDD});
        wr_req = 1'b1; wr_addr = 18'h00042; wr_byte = 8'h5A;
        step();
        n = 0;
        while (!wr_done && n < 30) begin step(); n++; end
        checks++; if (n !== LAT + 3) $display("FAIL rmw_latency: got %0d want %0d", n, LAT + 3); else passed++;
        checks++; if (we_cnt !== base + 1) $display("FAIL rmw_we_count: got %0d want %0d", we_cnt - base, 1); else passed++;
        checks++;
        if (obs_wr_q.size() == 0) $display("FAIL rmw_write: got no write want %h", exp_wr_q[0]);
        else begin
            got = obs_wr_q.pop_front(); exp = exp_wr_q.pop_front();
            if (got !== exp) $display("FAIL rmw_write: got %h want %h", got, exp); else passed++;
        end
        repeat (3) step();
        checks++; if (wr_done !== 1'b1) $display("FAIL rmw_done_hold: got %b want 1", wr_done); else passed++;
        checks++; if (we_cnt !== base + 1) $display("FAIL rmw_no_rewrite: got %0d want %0d", we_cnt - base, 1); else passed++;
        wr_req = 1'b0;
        step();
        checks++; if (wr_done !== 1'b0) $display("FAIL rmw_done_drop: got %b want 0", wr_done); else passed++;
        checks++; if (mem[16'h0010] !== 32'hAA5ACCDD) $display("FAIL rmw_ram_word: got %h want aa5accdd", mem[16'h0010]); else passed++;
    endtask

    task automatic test_collision();
        int n, base;
        logic [31:0] gv, ev;
        logic [47:0] gw, ew;
        preload(16'd3, 32'h0BADF00D);
        preload(16'h0020, 32'h11223344);
        exp_vga_q.push_back(32'h0BADF00D);
        exp_wr_q.push_back({16'h0020, 32'h112233EE});
        base = we_cnt;
        vga_req = 1'b1; vga_addr = 16'd3;
        wr_req = 1'b1; wr_addr = {16'h0020, 2'b00}; wr_byte = 8'hEE;
        step();
        vga_req = 1'b0;
        n = 0;
        while (!vga_valid && n < 30) begin step(); n++; end
        checks++; if (n !== LAT + 1) $display("FAIL coll_vga_first: got latency %0d want %0d", n, LAT + 1); else passed++;
        checks++; if (we_cnt !== base) $display("FAIL coll_no_early_write: got %0d want 0", we_cnt - base); else passed++;
        n = 0;
        while (!wr_done && n < 30) begin step(); n++; end
        checks++; if (we_cnt !== base + 1) $display("FAIL coll_one_write: got %0d want 1", we_cnt - base); else passed++;
        checks++;
        if (obs_vga_q.size() == 0) $display("FAIL coll_vga_data: got no read want %h", exp_vga_q[0]);
        else begin
            gv = obs_vga_q.pop_front(); ev = exp_vga_q.pop_front();
            if (gv !== ev) $display("FAIL coll_vga_data: got %h want %h", gv, ev); else passed++;
        end
        checks++;
        if (obs_wr_q.size() == 0) $display("FAIL coll_write: got no write want %h", exp_wr_q[0]);
        else begin
            gw = obs_wr_q.pop_front(); ew = exp_wr_q.pop_front();
            if (gw !== ew) $display("FAIL coll_write: got %h want %h", gw, ew); else passed++;
        end
        wr_req = 1'b0;
        step();
    endtask

    task automatic test_lanes();
        int n;
        logic [31:0] tmp;
        logic [7:0]  pix;
        logic [47:0] gw, ew;
        for (int lane = 0; lane < 4; lane++) begin
            pix = 8'($urandom_range(0, 255));
            preload(16'(16'h0050 + lane), 32'h01234567);
            tmp = 32'h01234567;
            tmp[lane*8 +: 8] = pix;
            exp_wr_q.push_back({16'(16'h0050 + lane), tmp});
            wr_req = 1'b1; wr_addr = {16'(16'h0050 + lane), 2'(lane)}; wr_byte = pix;
            step();
            n = 0;
            while (!wr_done && n < 30) begin step(); n++; end
            checks++;
            if (obs_wr_q.size() == 0) $display("FAIL lane%0d_write: got no write want %h", lane, exp_wr_q[0]);
            else begin
                gw = obs_wr_q.pop_front(); ew = exp_wr_q.pop_front();
                if (gw !== ew) $display("FAIL lane%0d_write: got %h want %h", lane, gw, ew); else passed++;
            end
            wr_req = 1'b0;
            step();
        end
    endtask

    task automatic test_pending();
        int n, base;
        logic [31:0] gv, ev;
        logic [47:0] gw, ew;
        preload(16'd7, 32'h77777777);
        preload(16'd9, 32'h99999999);
        preload(16'h0030, 32'hDEADBEEF);
        exp_wr_q.push_back({16'h0030, 32'hDEAD11EF});
        exp_vga_q.push_back(32'h99999999);
        base = we_cnt;
        checks++; if (vga_miss !== 1'b0) $display("FAIL pend_miss_before: got %b want 0", vga_miss); else passed++;
        wr_req = 1'b1; wr_addr = {16'h0030, 2'b01}; wr_byte = 8'h11;
        step();
        vga_req = 1'b1; vga_addr = 16'd7;
        step();
        vga_addr = 16'd9;
        step();
        vga_req = 1'b0;
        checks++; if (vga_miss !== 1'b1) $display("FAIL pend_miss_set: got %b want 1", vga_miss); else passed++;
        n = 0;
        while (!wr_done && n < 30) begin step(); n++; end
        checks++; if (obs_vga_q.size() !== 0) $display("FAIL pend_after_write: got %0d reads before wr_done want 0", obs_vga_q.size()); else passed++;
        n = 0;
        while (!vga_valid && n < 30) begin step(); n++; end
        step();
        checks++;
        if (obs_vga_q.size() == 0) $display("FAIL pend_vga_data: got no read want %h", exp_vga_q[0]);
        else begin
            gv = obs_vga_q.pop_front(); ev = exp_vga_q.pop_front();
            if (gv !== ev) $display("FAIL pend_vga_data: got %h want %h", gv, ev); else passed++;
        end
        checks++;
        if (obs_wr_q.size() == 0) $display("FAIL pend_write: got no write want %h", exp_wr_q[0]);
        else begin
            gw = obs_wr_q.pop_front(); ew = exp_wr_q.pop_front();
            if (gw !== ew) $display("FAIL pend_write: got %h want %h", gw, ew); else passed++;
        end
        repeat (LAT + 4) step();
        checks++; if (obs_vga_q.size() !== 0 || we_cnt !== base + 1) $display("FAIL pend_single: got %0d extra reads %0d writes want 0 and 1", obs_vga_q.size(), we_cnt - base); else passed++;
`ifdef FB_ARB_STATS_EN
        checks++; if (miss_count !== 16'd1) $display("FAIL pend_miss_count: got %0d want 1", miss_count); else passed++;
`endif
        wr_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int n, base;
        logic [47:0] gw, ew;
        preload(16'h0040, 32'hCAFEBABE);
        base = we_cnt;
        wr_req = 1'b1; wr_addr = {16'h0040, 2'b11}; wr_byte = 8'h77;
        step();
        repeat (LAT) step();
        checks++; if (busy !== 1'b1) $display("FAIL rst_mid_busy: got %b want 1", busy); else passed++;
        reset = 1'b1; wr_req = 1'b0;
        step();
        checks++; if (ram_we !== 1'b0 || busy !== 1'b0 || wr_done !== 1'b0) $display("FAIL rst_mid_ctrl: got we=%b busy=%b done=%b want 0 0 0", ram_we, busy, wr_done); else passed++;
        checks++; if (vga_miss !== 1'b0 || ram_addr !== 16'd0 || ram_wdata !== 32'd0) $display("FAIL rst_mid_outputs: got miss=%b addr=%h wdata=%h want 0", vga_miss, ram_addr, ram_wdata); else passed++;
        reset = 1'b0;
        repeat (4) step();
        checks++; if (we_cnt !== base) $display("FAIL rst_mid_no_commit: got %0d writes want 0", we_cnt - base); else passed++;
        checks++; if (mem[16'h0040] !== 32'hCAFEBABE) $display("FAIL rst_mid_ram: got %h want cafebabe", mem[16'h0040]); else passed++;
`ifdef FB_ARB_STATS_EN
        checks++; if (miss_count !== 16'd0 || wr_count !== 16'd0) $display("FAIL rst_mid_stats: got %0d %0d want 0 0", miss_count, wr_count); else passed++;
`endif
        exp_wr_q.push_back({16'h0040, 32'h77FEBABE});
        wr_req = 1'b1;
        step();
        n = 0;
        while (!wr_done && n < 30) begin step(); n++; end
        checks++; if (n !== LAT + 3) $display("FAIL rst_mid_retry_latency: got %0d want %0d", n, LAT + 3); else passed++;
        checks++;
        if (obs_wr_q.size() == 0) $display("FAIL rst_mid_retry_write: got no write want %h", exp_wr_q[0]);
        else begin
            gw = obs_wr_q.pop_front(); ew = exp_wr_q.pop_front();
            if (gw !== ew) $display("FAIL rst_mid_retry_write: got %h want %h", gw, ew); else passed++;
        end
`ifdef FB_ARB_STATS_EN
        checks++; if (wr_count !== 16'd1) $display("FAIL rst_mid_wr_count: got %0d want 1", wr_count); else passed++;
`endif
        wr_req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_vga_read();
        test_rmw();
        test_collision();
        test_lanes();
        test_pending();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want summary");
        $fatal(1);
    end
endmodule
